// File: rtl/gpu_ram_pkg.sv
// Shared types and defaults for the layer-data RAM arbiter.
package gpu_ram_pkg;

    localparam int unsigned ADDR_W_DEF = 20;
    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } ramState_e;

    typedef enum logic {
        OWNER_PIPE = 1'b0,
        OWNER_HOST = 1'b1
    } owner_e;

endpackage

// File: rtl/ram_access_timer.sv
// Loadable down-counter that times the strobe phase of one RAM access.
module ram_access_timer #(
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic clear,
    input  logic tick,
    output logic last
);

    logic [3:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= 4'(ACCESS_CYCLES);
        end else if (tick && (count != '0)) begin
            count <= count - 4'd1;
        end
    end

    // count reaches 1 on the final strobe cycle; the edge ending it completes the access
    assign last = (count == 4'd1);

endmodule

// File: rtl/ram_arbiter.sv
// Shares the external layer-data RAM between the pixel pipeline (reads) and the
// host command path (reads/writes) using fixed-length strobed accesses.
module ram_arbiter
    import gpu_ram_pkg::*;
#(
    parameter int unsigned ADDR_W        = ADDR_W_DEF,
    parameter int unsigned DATA_W        = DATA_W_DEF,
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter int unsigned STARVE_MAX    = 4
) (
    input  logic              gpuClock,
    input  logic              reset,
    input  logic              pipeReq,
    input  logic [ADDR_W-1:0] pipeAddr,
    input  logic              pipeAbort,
    output logic              pipeDone,
    output logic [DATA_W-1:0] pipeData,
    input  logic              hostReq,
    input  logic              hostWrite,
    input  logic [ADDR_W-1:0] hostAddr,
    input  logic [DATA_W-1:0] hostWData,
    output logic              hostDone,
    output logic [DATA_W-1:0] hostRData,
    output logic              memCs,
    output logic              memOe,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWData,
    input  logic [DATA_W-1:0] memRData
);

    localparam int unsigned         STARVE_W     = $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(STARVE_MAX);

    ramState_e           state;
    ramState_e           nextState;
    owner_e              owner;
    logic                writeReg;
    logic [STARVE_W-1:0] starveCnt;

    logic pipeCand;
    logic hostWins;
    logic grant;
    logic abortNow;
    logic finishNow;
    logic timerLast;
    logic inAccess;

    always_comb begin
        inAccess  = (state == ACCESS);
        pipeCand  = pipeReq && !pipeAbort;
        hostWins  = hostReq && (!pipeCand || (starveCnt == STARVE_LIMIT));
        grant     = (state == IDLE) && (pipeCand || hostReq);
        abortNow  = inAccess && (owner == OWNER_PIPE) && pipeAbort;
        finishNow = inAccess && timerLast && !abortNow;
    end

    ram_access_timer #(
        .ACCESS_CYCLES(ACCESS_CYCLES)
    ) accessTimer (
        .clk  (gpuClock),
        .rst  (reset),
        .load (grant),
        .clear(abortNow),
        .tick (inAccess),
        .last (timerLast)
    );

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (grant) nextState = ACCESS;
            ACCESS: begin
                if (abortNow) begin
                    nextState = IDLE;
                end else if (timerLast) begin
                    nextState = DONE;
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge gpuClock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge gpuClock or posedge reset) begin
        if (reset) begin
            owner     <= OWNER_PIPE;
            writeReg  <= 1'b0;
            memAddr   <= '0;
            memWData  <= '0;
            starveCnt <= '0;
            pipeData  <= '0;
            hostRData <= '0;
        end else begin
            if (grant) begin
                if (hostWins) begin
                    owner     <= OWNER_HOST;
                    writeReg  <= hostWrite;
                    memAddr   <= hostAddr;
                    memWData  <= hostWData;
                    starveCnt <= '0;
                end else begin
                    owner    <= OWNER_PIPE;
                    writeReg <= 1'b0;
                    memAddr  <= pipeAddr;
                    // only grants that overtake a waiting host count towards starvation
                    if (hostReq && (starveCnt != STARVE_LIMIT)) begin
                        starveCnt <= starveCnt + 1'b1;
                    end
                end
            end
            if (finishNow && !writeReg) begin
                if (owner == OWNER_PIPE) begin
                    pipeData <= memRData;
                end else begin
                    hostRData <= memRData;
                end
            end
        end
    end

    // strobes and done pulses decode straight from registered state so reset kills them at once
    always_comb begin
        memCs    = inAccess;
        memOe    = inAccess && !writeReg;
        memWe    = inAccess && writeReg;
        pipeDone = (state == DONE) && (owner == OWNER_PIPE);
        hostDone = (state == DONE) && (owner == OWNER_HOST);
    end

endmodule
